// File: rtl/mss_pkg.sv
// Shared constants for the Music/Speech SOC host mailbox: register addresses,
// status/control bit positions and SOC PORT_C strobe bit positions.
package mss_pkg;

  // Host register addresses
  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_STAT = 1'b1;

  // Status register bits
  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_RVALID  = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 4;
  localparam int unsigned ST_IRQEN   = 7;

  // Control register bits
  localparam int unsigned CT_IRQEN = 0;
  localparam int unsigned CT_FLUSH = 7;

  // SOC PORT_C strobe bits
  localparam int unsigned PC_POP   = 0;
  localparam int unsigned PC_RLOAD = 1;

  function automatic logic [7:0] pack_status(input logic       full,
                                             input logic       empty,
                                             input logic       rvalid,
                                             input logic       ovf,
                                             input logic [2:0] cnt,
                                             input logic       irq_en);
    logic [7:0] s;
    s                    = '0;
    s[ST_FULL]           = full;
    s[ST_EMPTY]          = empty;
    s[ST_RVALID]         = rvalid;
    s[ST_OVF]            = ovf;
    s[ST_CNT_LSB +: 3]   = cnt;
    s[ST_IRQEN]          = irq_en;
    return s;
  endfunction

endpackage

// File: rtl/mss_cmd_fifo.sv
// Command FIFO feeding the SOC: push/pop/flush with registered head byte and
// empty flag. A pop on a full FIFO makes room for a same-cycle push.
module mss_cmd_fifo #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        flush,
  input  logic [7:0]                  din,
  output logic [7:0]                  head,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        full,
  output logic                        empty,
  output logic                        dropped
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    head_q, head_d;
  logic          empty_q;
  logic          do_push, do_pop;

  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign empty = empty_q;
  assign count = count_q;
  assign head  = head_q;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && (!full || do_pop);
    dropped  = push && !do_push && !flush;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
    // A lone entry that was pushed this cycle is not in mem_q yet.
    if (count_d == '0) begin
      head_d = '0;
    end else if (do_push && !flush && count_d == CW'(1)) begin
      head_d = din;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      empty_q  <= 1'b1;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      empty_q  <= (count_d == '0);
    end
  end

endmodule

// File: rtl/mss_host_mailbox.sv
// Host command/reply mailbox in front of the Music/Speech SOC.
// Define MSS_HOST_IRQ_EN to enable the host reply interrupt and its enable bit.
module mss_host_mailbox
  import mss_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       CLKIN,
  input  logic       RESET,
  input  logic       HOST_WR,
  input  logic       HOST_RD,
  input  logic       HOST_ADDR,
  input  logic [7:0] HOST_DIN,
  output logic [7:0] HOST_DOUT,
  input  logic [7:0] SOC_PORT_C,
  input  logic [7:0] SOC_PORT_D_OUT,
  output logic [7:0] SOC_PORT_D_IN,
  output logic       INT1_N,
  output logic       HOST_IRQ
);

  logic [1:0] pc_hist_q;
  logic       pop_edge, rload_edge;
  logic       wr_data, wr_ctrl, rd_data, flush;
  logic       ovf_q, ovf_d;
  logic       rvalid_q, rvalid_d;
  logic [7:0] reply_q, reply_d;
  logic [7:0] dout_q, dout_d;
  logic [7:0] status;
  logic       irq_en;

  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        fifo_full, fifo_empty, fifo_dropped;
  logic [7:0]                  fifo_head;

  assign pop_edge   = SOC_PORT_C[PC_POP] & ~pc_hist_q[0];
  assign rload_edge = SOC_PORT_C[PC_RLOAD] & ~pc_hist_q[1];
  assign wr_data    = HOST_WR && (HOST_ADDR == ADDR_DATA);
  assign wr_ctrl    = HOST_WR && (HOST_ADDR == ADDR_STAT);
  assign rd_data    = HOST_RD && (HOST_ADDR == ADDR_DATA);
  assign flush      = wr_ctrl && HOST_DIN[CT_FLUSH];

  mss_cmd_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk    (CLKIN),
    .rst    (RESET),
    .push   (wr_data),
    .pop    (pop_edge),
    .flush  (flush),
    .din    (HOST_DIN),
    .head   (fifo_head),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .dropped(fifo_dropped)
  );

  assign SOC_PORT_D_IN = fifo_head;
  assign INT1_N        = fifo_empty;
  assign HOST_DOUT     = dout_q;

  assign status = pack_status(fifo_full, fifo_empty, rvalid_q, ovf_q, 3'(fifo_count), irq_en);

  always_comb begin
    ovf_d    = ovf_q;
    reply_d  = reply_q;
    rvalid_d = rvalid_q;
    dout_d   = dout_q;
    if (flush) begin
      ovf_d = 1'b0;
    end else if (fifo_dropped) begin
      ovf_d = 1'b1;
    end
    if (rload_edge) reply_d = SOC_PORT_D_OUT;
    // A reply load beats a same-cycle host read; the read still sees the old byte.
    if (flush) begin
      rvalid_d = 1'b0;
    end else if (rload_edge) begin
      rvalid_d = 1'b1;
    end else if (rd_data) begin
      rvalid_d = 1'b0;
    end
    if (HOST_RD) dout_d = (HOST_ADDR == ADDR_DATA) ? reply_q : status;
  end

  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      pc_hist_q <= 2'b11;
      ovf_q     <= 1'b0;
      reply_q   <= '0;
      rvalid_q  <= 1'b0;
      dout_q    <= '0;
    end else begin
      pc_hist_q <= {SOC_PORT_C[PC_RLOAD], SOC_PORT_C[PC_POP]};
      ovf_q     <= ovf_d;
      reply_q   <= reply_d;
      rvalid_q  <= rvalid_d;
      dout_q    <= dout_d;
    end
  end

`ifdef MSS_HOST_IRQ_EN
  logic irq_en_q, irq_q;

  assign irq_en   = irq_en_q;
  assign HOST_IRQ = irq_q;

  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en_q <= HOST_DIN[CT_IRQEN];
      irq_q <= rvalid_q & irq_en_q;
    end
  end

  logic unused_in;
  assign unused_in = ^{SOC_PORT_C[7:2], HOST_DIN[6:1]};
`else
  assign irq_en   = 1'b0;
  assign HOST_IRQ = 1'b0;

  logic unused_in;
  assign unused_in = ^{SOC_PORT_C[7:2], HOST_DIN[6:0]};
`endif

endmodule
